// File: rtl/cake_game_pkg.sv
// cake_game_pkg: shared definitions for the cake-assembly minigame.
//   - FSM state encodings (also driven out on the estado port)
//   - recipe ROM contents and layer counts for easy/hard mode
//   - default timeout / visibility constants
//   - helper returning the expected one-hot button vector for a code
package cake_game_pkg;

  typedef enum logic [3:0] {
    S_INICIAL  = 4'h0,
    S_PREPARA  = 4'h1,
    S_MOSTRA   = 4'h2,
    S_ESPERA   = 4'h3,
    S_REGISTRA = 4'h4,
    S_COMPARA  = 4'h5,
    S_PROXIMA  = 4'h6,
    S_FIM      = 4'hF
  } state_t;

  localparam int LAYERS_FACIL   = 4;
  localparam int LAYERS_DIFICIL = 7;

  localparam logic [2:0] LAST_IDX_FACIL   = 3'(LAYERS_FACIL - 1);
  localparam logic [2:0] LAST_IDX_DIFICIL = 3'(LAYERS_DIFICIL - 1);

  localparam int DEF_TIMEOUT_FACIL   = 2000;
  localparam int DEF_TIMEOUT_DIFICIL = 1000;
  localparam int DEF_SHOW_DIFICIL    = 300;

  // Fixed recipe: ingredient code for each layer index.
  function automatic logic [2:0] recipe_code(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = 3'd1;
      3'd1:    code = 3'd4;
      3'd2:    code = 3'd2;
      3'd3:    code = 3'd7;
      3'd4:    code = 3'd3;
      3'd5:    code = 3'd6;
      3'd6:    code = 3'd5;
      default: code = 3'd0;
    endcase
    return code;
  endfunction

  // Button i selects ingredient code i+1, so code c maps to bit c-1.
  function automatic logic [6:0] onehot_for(input logic [2:0] code);
    return 7'(7'd1 << (code - 3'd1));
  endfunction

endpackage

// File: rtl/cake_recipe_rom.sv
// cake_recipe_rom: combinational recipe lookup.
//   i_idx  in  3 : layer index 0..6
//   o_code out 3 : ingredient code for that layer (1..7)
module cake_recipe_rom
  import cake_game_pkg::*;
(
  input  logic [2:0] i_idx,
  output logic [2:0] o_code
);

  assign o_code = recipe_code(i_idx);

endmodule

// File: rtl/cake_game.sv
// cake_game: cake-assembly minigame.
// LEDs show an ingredient code; the player must press the matching button
// before the per-layer timeout. Score counts correctly stacked layers.
//   clock       in  1 : system clock
//   reset       in  1 : asynchronous active-low reset
//   jogar       in  1 : start / restart request (INICIAL and FIM only)
//   dificuldade in  1 : 0 = easy (4 layers), 1 = hard (7 layers)
//   botoes      in  7 : buttons, bit i selects code i+1
//   estado      out 4 : current FSM state code
//   jogadas     out 7 : last registered button vector
//   leds        out 3 : displayed ingredient code, 0 = blank
//   pontuacao   out 3 : correct layers placed
//   pronto      out 1 : round finished (FIM)
module cake_game
  import cake_game_pkg::*;
#(
  parameter int TIMEOUT_FACIL   = DEF_TIMEOUT_FACIL,
  parameter int TIMEOUT_DIFICIL = DEF_TIMEOUT_DIFICIL,
  parameter int SHOW_DIFICIL    = DEF_SHOW_DIFICIL
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       dificuldade,
  input  logic [6:0] botoes,
  output logic [3:0] estado,
  output logic [6:0] jogadas,
  output logic [2:0] leds,
  output logic [2:0] pontuacao,
  output logic       pronto
);

  localparam logic [15:0] L_LAST_FACIL   = 16'(TIMEOUT_FACIL - 1);
  localparam logic [15:0] L_LAST_DIFICIL = 16'(TIMEOUT_DIFICIL - 1);
  localparam logic [15:0] L_SHOW_DIFICIL = 16'(SHOW_DIFICIL);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_idx;
  logic [2:0]  r_score;
  logic [6:0]  r_jogadas;
  logic [15:0] r_timer;
  logic        r_dif;
  logic [2:0]  r_ingr;
  logic        r_prev;

  logic [2:0]  w_rom_code;
  logic        w_press;
  logic        w_timeout;
  logic        w_match;
  logic        w_last_layer;
  logic        w_show;

  cake_recipe_rom u_rom (
    .i_idx  (r_idx),
    .o_code (w_rom_code)
  );

  // A press is the rising edge of "any button down"; a button held from an
  // earlier layer or state keeps r_prev high and never counts again.
  assign w_press      = (|botoes) & ~r_prev;
  assign w_timeout    = (r_timer == (r_dif ? L_LAST_DIFICIL : L_LAST_FACIL));
  assign w_match      = (r_jogadas == onehot_for(r_ingr));
  assign w_last_layer = (r_idx == (r_dif ? LAST_IDX_DIFICIL : LAST_IDX_FACIL));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_INICIAL;
    else        r_state <= w_next;
  end

  // Next-state logic; a press in the final timer cycle beats the timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INICIAL:  if (jogar) w_next = S_PREPARA;
      S_PREPARA:  w_next = S_MOSTRA;
      S_MOSTRA:   w_next = S_ESPERA;
      S_ESPERA: begin
        if (w_press)        w_next = S_REGISTRA;
        else if (w_timeout) w_next = S_FIM;
      end
      S_REGISTRA: w_next = S_COMPARA;
      S_COMPARA: begin
        if (w_match && !w_last_layer) w_next = S_PROXIMA;
        else                          w_next = S_FIM;
      end
      S_PROXIMA:  w_next = S_MOSTRA;
      S_FIM:      if (jogar) w_next = S_PREPARA;
      default:    w_next = S_INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx     <= '0;
      r_score   <= '0;
      r_jogadas <= '0;
      r_timer   <= '0;
      r_dif     <= 1'b0;
      r_ingr    <= '0;
      r_prev    <= 1'b0;
    end else begin
      r_prev <= |botoes;
      case (r_state)
        S_PREPARA: begin
          r_idx     <= '0;
          r_score   <= '0;
          r_jogadas <= '0;
          r_timer   <= '0;
          r_dif     <= dificuldade;
        end
        S_MOSTRA: begin
          r_ingr  <= w_rom_code;
          r_timer <= '0;
        end
        S_ESPERA:   r_timer   <= r_timer + 16'd1;
        S_REGISTRA: r_jogadas <= botoes;
        S_COMPARA:  if (w_match) r_score <= r_score + 3'd1;
        S_PROXIMA:  r_idx <= r_idx + 3'd1;
        default: ;
      endcase
    end
  end

  // Hard mode hides the ingredient after the show window while waiting.
  always_comb begin
    w_show = 1'b0;
    case (r_state)
      S_MOSTRA, S_REGISTRA, S_COMPARA: w_show = 1'b1;
      S_ESPERA: w_show = !(r_dif && (r_timer >= L_SHOW_DIFICIL));
      default:  w_show = 1'b0;
    endcase
  end

  assign estado    = r_state;
  assign jogadas   = r_jogadas;
  assign leds      = w_show ? r_ingr : 3'd0;
  assign pontuacao = r_score;
  assign pronto    = (r_state == S_FIM);

endmodule

// File: tb/tb_cake_game.sv
// tb_cake_game: directed self-checking bench for cake_game.
module tb_cake_game;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       jogar = 1'b0;
  logic       dificuldade = 1'b0;
  logic [6:0] botoes = 7'd0;
  logic [3:0] estado;
  logic [6:0] jogadas;
  logic [2:0] leds;
  logic [2:0] pontuacao;
  logic       pronto;

  int errors = 0;
  int checks = 0;
  int recipe[7] = '{1, 4, 2, 7, 3, 6, 5};

  cake_game #(
    .TIMEOUT_FACIL   (20),
    .TIMEOUT_DIFICIL (40),
    .SHOW_DIFICIL    (5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .jogar       (jogar),
    .dificuldade (dificuldade),
    .botoes      (botoes),
    .estado      (estado),
    .jogadas     (jogadas),
    .leds        (leds),
    .pontuacao   (pontuacao),
    .pronto      (pronto)
  );

  always #5 clock = ~clock;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // From INICIAL/FIM: PREPARA, MOSTRA, then land on ESPERA entry.
  task automatic start_game(input logic dif);
    jogar = 1'b1;
    dificuldade = dif;
    tick();
    jogar = 1'b0;
    tick();
    tick();
  endtask

  // Press in ESPERA, hold through REGISTRA, release; ends after COMPARA.
  task automatic do_press(input logic [6:0] vec);
    botoes = vec;
    tick();
    tick();
    botoes = 7'd0;
    tick();
  endtask

  function automatic logic [6:0] hot(input int code);
    return 7'(1 << (code - 1));
  endfunction

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({estado, jogadas, leds, pontuacao, pronto} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {estado, jogadas, leds, pontuacao, pronto});
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (estado !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_idle_state: got %h expected 0", estado);
    end
  endtask

  task automatic test_easy_perfect();
    start_game(1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (leds !== 3'(recipe[k]) || estado !== 4'h3) begin
        errors++;
        $display("[TB] FAIL easy_leds_%0d: got leds=%0d estado=%h expected leds=%0d estado=3", k, leds, estado, recipe[k]);
      end
      do_press(hot(recipe[k]));
      if (k < 3) begin
        checks++;
        if (estado !== 4'h6 || pontuacao !== 3'(k + 1)) begin
          errors++;
          $display("[TB] FAIL easy_verdict_%0d: got estado=%h score=%0d expected estado=6 score=%0d", k, estado, pontuacao, k + 1);
        end
        tick();
        tick();
      end
    end
    checks++;
    if (pontuacao !== 3'd4 || estado !== 4'hF || pronto !== 1'b1 || leds !== 3'd0) begin
      errors++;
      $display("[TB] FAIL easy_final: got score=%0d estado=%h pronto=%b leds=%0d expected 4 F 1 0", pontuacao, estado, pronto, leds);
    end
  endtask

  task automatic test_wrong_ingredient();
    start_game(1'b0);
    do_press(7'b0000010);
    checks++;
    if (estado !== 4'hF || pontuacao !== 3'd0 || jogadas !== 7'b0000010 || pronto !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrong_ingredient: got estado=%h score=%0d jogadas=%b pronto=%b expected F 0 0000010 1", estado, pontuacao, jogadas, pronto);
    end
  endtask

  task automatic test_timeout();
    start_game(1'b0);
    checks++;
    if (jogadas !== 7'd0) begin
      errors++;
      $display("[TB] FAIL restart_clears_jogadas: got %b expected 0000000", jogadas);
    end
    for (int i = 0; i < 19; i++) tick();
    checks++;
    if (estado !== 4'h3) begin
      errors++;
      $display("[TB] FAIL timeout_early: got estado=%h expected 3", estado);
    end
    tick();
    checks++;
    if (estado !== 4'hF || pontuacao !== 3'd0 || pronto !== 1'b1 || leds !== 3'd0) begin
      errors++;
      $display("[TB] FAIL timeout_fim: got estado=%h score=%0d pronto=%b leds=%0d expected F 0 1 0", estado, pontuacao, pronto, leds);
    end
  endtask

  task automatic test_press_at_deadline();
    start_game(1'b0);
    for (int i = 0; i < 19; i++) tick();
    do_press(hot(recipe[0]));
    checks++;
    if (estado !== 4'h6 || pontuacao !== 3'd1) begin
      errors++;
      $display("[TB] FAIL deadline_press: got estado=%h score=%0d expected 6 1", estado, pontuacao);
    end
  endtask

  task automatic test_hard_mode();
    reset = 1'b0;
    #1 reset = 1'b1;
    tick();
    start_game(1'b1);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (leds !== 3'd1) begin
      errors++;
      $display("[TB] FAIL hard_show_window: got leds=%0d expected 1", leds);
    end
    tick();
    checks++;
    if (leds !== 3'd0 || estado !== 4'h3) begin
      errors++;
      $display("[TB] FAIL hard_blank: got leds=%0d estado=%h expected 0 3", leds, estado);
    end
    for (int i = 0; i < 5; i++) tick();
    do_press(hot(recipe[0]));
    checks++;
    if (pontuacao !== 3'd1 || estado !== 4'h6) begin
      errors++;
      $display("[TB] FAIL hard_late_press: got score=%0d estado=%h expected 1 6", pontuacao, estado);
    end
    for (int k = 1; k < 7; k++) begin
      tick();
      tick();
      checks++;
      if (leds !== 3'(recipe[k])) begin
        errors++;
        $display("[TB] FAIL hard_leds_%0d: got %0d expected %0d", k, leds, recipe[k]);
      end
      do_press(hot(recipe[k]));
    end
    checks++;
    if (pontuacao !== 3'd7 || estado !== 4'hF || pronto !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hard_final: got score=%0d estado=%h pronto=%b expected 7 F 1", pontuacao, estado, pronto);
    end
  endtask

  task automatic test_held_and_multi();
    start_game(1'b0);
    botoes = 7'b0000001;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (estado !== 4'h6 || pontuacao !== 3'd1) begin
      errors++;
      $display("[TB] FAIL held_first: got estado=%h score=%0d expected 6 1", estado, pontuacao);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (estado !== 4'h3 || leds !== 3'd4) begin
      errors++;
      $display("[TB] FAIL held_no_repress: got estado=%h leds=%0d expected 3 4", estado, leds);
    end
    botoes = 7'd0;
    tick();
    do_press(7'b0001000);
    checks++;
    if (estado !== 4'h6 || pontuacao !== 3'd2) begin
      errors++;
      $display("[TB] FAIL held_after_release: got estado=%h score=%0d expected 6 2", estado, pontuacao);
    end
    tick();
    tick();
    do_press(7'b0001001);
    checks++;
    if (estado !== 4'hF || pontuacao !== 3'd2 || jogadas !== 7'b0001001) begin
      errors++;
      $display("[TB] FAIL multi_press: got estado=%h score=%0d jogadas=%b expected F 2 0001001", estado, pontuacao, jogadas);
    end
  endtask

  task automatic test_reset_mid_round();
    start_game(1'b0);
    do_press(hot(recipe[0]));
    tick();
    tick();
    do_press(hot(recipe[1]));
    tick();
    tick();
    checks++;
    if (estado !== 4'h3 || pontuacao !== 3'd2) begin
      errors++;
      $display("[TB] FAIL midround_setup: got estado=%h score=%0d expected 3 2", estado, pontuacao);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({estado, jogadas, leds, pontuacao, pronto} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL midround_reset: got %h expected 0", {estado, jogadas, leds, pontuacao, pronto});
    end
    #1 reset = 1'b1;
    tick();
    start_game(1'b0);
    checks++;
    if (estado !== 4'h3 || leds !== 3'd1 || pontuacao !== 3'd0) begin
      errors++;
      $display("[TB] FAIL midround_restart: got estado=%h leds=%0d score=%0d expected 3 1 0", estado, leds, pontuacao);
    end
  endtask

  initial begin
    $display("[TB] cake_game directed bench");
    test_reset();
    test_easy_perfect();
    test_wrong_ingredient();
    test_timeout();
    test_press_at_deadline();
    test_hard_mode();
    test_held_and_multi();
    test_reset_mid_round();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
